// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared 4-bit ALU, one operation per three cycles.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every tie instead of round-robin.
module alu_arbiter (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [1:0] req,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic [7:0] result,
  output logic       busy,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_func_n,
  input  logic [7:0] alu_result
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2} state_t;
  state_t state, state_nxt;
  logic win, win_q;
  logic [2:0] op_q;
  logic [3:0] a_q, b_q;
`ifdef ALU_ARB_FIXED_PRIO_EN
  assign win = ~req[0];
`else
  logic ptr;
  // ptr remembers the last winner; the other requester takes a tie
  assign win = req[1] & (~req[0] | ~ptr);
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) ptr <= 1'b1;
    else if (state == ISSUE) ptr <= win_q;
`endif
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == IDLE) ? (|req ? ISSUE : IDLE) : (state == ISSUE) ? CAPTURE : IDLE;
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      gnt <= 2'b00;
      done <= 2'b00;
      result <= 8'h00;
      win_q <= 1'b0;
      op_q <= 3'd0;
      a_q <= 4'd0;
      b_q <= 4'd0;
    end else begin
      gnt <= 2'b00;
      done <= 2'b00;
      if (state == IDLE && |req) begin
        win_q <= win;
        op_q <= win ? op1 : op0;
        a_q <= win ? a1 : a0;
        b_q <= win ? b1 : b0;
        gnt <= win ? 2'b10 : 2'b01;
      end
      if (state == ISSUE) begin
        result <= alu_result;
        done <= win_q ? 2'b10 : 2'b01;
      end
    end
  always_comb begin
    busy = state != IDLE;
    alu_a = a_q;
    alu_b = b_q;
    alu_func_n = ~op_q;
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: random and directed stimulus against a transaction-level model of the arbiter.
module tb_alu_arbiter;
  logic Clock = 1'b0, Resetn = 1'b1;
  logic [1:0] req = 2'b00;
  logic [2:0] op0 = 3'd0, op1 = 3'd0;
  logic [3:0] a0 = 4'd0, b0 = 4'd0, a1 = 4'd0, b1 = 4'd0;
  logic [1:0] gnt, done;
  logic [7:0] result, alu_result;
  logic busy;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_func_n;
  int n_chk = 0, n_pass = 0;
  bit run = 1'b0;

  always #5 Clock = ~Clock;

  // the team ALU: 0 pass a, 1 add, 2 sub, 3 and, 4 xor, 5 {b,~a}, 6 mul, 7 zero
  function automatic logic [7:0] alu_ref(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
    case (f)
      3'd0: return {4'h0, a};
      3'd1: return {4'h0, a} + {4'h0, b};
      3'd2: return {4'h0, a} - {4'h0, b};
      3'd3: return {4'h0, a & b};
      3'd4: return {4'h0, a ^ b};
      3'd5: return {b, ~a};
      3'd6: return {4'h0, a} * {4'h0, b};
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_ref(~alu_func_n, alu_a, alu_b);

  alu_arbiter dut (
    .Clock(Clock), .Resetn(Resetn), .req(req),
    .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .done(done), .result(result), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func_n(alu_func_n), .alu_result(alu_result)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int win_ref(input logic [1:0] r, input int last);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return r == 2'b10 ? 1 : 0;
`else
    return r == 2'b01 ? 0 : r == 2'b10 ? 1 : 1 - last;
`endif
  endfunction

  // model: a transaction is granted, then completes one cycle later, then one idle cycle follows
  int phase = 0, m_w = 0, m_last = 1;
  logic [1:0] m_gnt = 2'b00, m_done = 2'b00;
  logic [7:0] m_res = 8'h00;
  logic [2:0] m_op = 3'd0, efn;
  logic [3:0] m_a = 4'd0, m_b = 4'd0;

  always @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      phase <= 0; m_gnt <= 2'b00; m_done <= 2'b00; m_res <= 8'h00;
      m_last <= 1; m_op <= 3'd0; m_a <= 4'd0; m_b <= 4'd0;
    end else if (phase == 0) begin
      if (req != 2'b00) begin
        m_w <= win_ref(req, m_last);
        m_op <= win_ref(req, m_last) == 1 ? op1 : op0;
        m_a <= win_ref(req, m_last) == 1 ? a1 : a0;
        m_b <= win_ref(req, m_last) == 1 ? b1 : b0;
        m_gnt <= 2'b01 << win_ref(req, m_last);
        phase <= 1;
      end
    end else if (phase == 1) begin
      m_gnt <= 2'b00;
      m_done <= 2'b01 << m_w;
      m_res <= alu_ref(m_op, m_a, m_b);
      m_last <= m_w;
      phase <= 2;
    end else begin
      m_done <= 2'b00;
      phase <= 0;
    end

  always @(negedge Clock)
    if (run) begin
      efn = ~m_op;
      chk("gnt", gnt, m_gnt);
      chk("done", done, m_done);
      chk("result", result, m_res);
      chk("busy", busy, phase != 0);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_func_n", alu_func_n, efn);
    end

  task automatic wait_gnt(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 8 && g == 2'b00; i++) begin
      @(negedge Clock);
      g = gnt;
    end
    chk("gnt_seen", g != 2'b00, 1);
  endtask

  task automatic do_op(input logic [1:0] r, output logic [1:0] g, output logic [1:0] d, output logic [7:0] res);
    req = r;
    wait_gnt(g);
    @(negedge Clock);
    d = done;
    res = result;
    req = r & ~d;
    @(negedge Clock);
  endtask

  task automatic pulse_reset();
    #2 Resetn = 1'b0;
    @(negedge Clock);
    #2 Resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] g, d;
    logic [7:0] res;
    logic [3:0] seq;
    #1 Resetn = 1'b0;
    repeat (2) @(negedge Clock);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_result", result, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_func_n", alu_func_n, 3'b111);
    run = 1'b1;
    #2 Resetn = 1'b1;
    // single op from requester 0: 3 + 5
    op0 = 3'd1; a0 = 4'd3; b0 = 4'd5;
    req = 2'b01;
    wait_gnt(g);
    chk("add_gnt", g, 2'b01);
    chk("add_busy_issue", busy, 1);
    @(negedge Clock);
    chk("add_done", done, 2'b01);
    chk("add_result", result, 8'h08);
    chk("add_busy_capture", busy, 1);
    req = 2'b00;
    @(negedge Clock);
    chk("add_busy_idle", busy, 0);
    chk("add_done_clear", done, 2'b00);
    // requester 1, op 5
    op1 = 3'd5; a1 = 4'hA; b1 = 4'h3;
    do_op(2'b10, g, d, res);
    chk("op5_gnt", g, 2'b10);
    chk("op5_done", d, 2'b10);
    chk("op5_result", res, 8'h35);
    // tie held for four operations from reset
    pulse_reset();
    seq = 4'd0;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g);
      seq = {seq[2:0], g[1]};
      @(negedge Clock);
    end
    req = 2'b00;
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("tie_order", seq, 4'b0000);
`else
    chk("tie_order", seq, 4'b0101);
`endif
    repeat (2) @(negedge Clock);
    // reset during ISSUE aborts the operation
    op0 = 3'd1; a0 = 4'd3; b0 = 4'd5;
    req = 2'b01;
    wait_gnt(g);
    #2 Resetn = 1'b0;
    req = 2'b00;
    @(negedge Clock);
    chk("abort_done", done, 2'b00);
    chk("abort_result", result, 8'h00);
    chk("abort_busy", busy, 0);
    #2 Resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      chk("abort_no_done", done, 2'b00);
    end
    do_op(2'b01, g, d, res);
    chk("after_abort_done", d, 2'b01);
    chk("after_abort_result", res, 8'h08);
    // operand change after grant must not leak into the operation
    op0 = 3'd1; a0 = 4'd3; b0 = 4'd5;
    req = 2'b01;
    wait_gnt(g);
    a0 = 4'd9;
    @(negedge Clock);
    chk("late_a_result", result, 8'h08);
    req = 2'b00;
    @(negedge Clock);
    // op 7 completes and yields zero
    op0 = 3'd7; a0 = 4'hF; b0 = 4'hF;
    do_op(2'b01, g, d, res);
    chk("op7_gnt", g, 2'b01);
    chk("op7_done", d, 2'b01);
    chk("op7_result", res, 8'h00);
    // random traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      @(negedge Clock);
      for (int i = 0; i < 2; i++)
        if (done[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(2) == 0) req[i] = 1'b1;
      op0 = 3'($urandom_range(7)); op1 = 3'($urandom_range(7));
      a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
      if ($urandom_range(99) == 0) pulse_reset();
    end
    req = 2'b00;
    repeat (4) @(negedge Clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
